// File: rtl/sa_output_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sa_output_collector_pkg
// Purpose  : Shared widths, FSM state encoding and the signed-16 saturation
//            helper for the systolic-array output collector.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sa_output_collector_pkg;

  localparam int DATA_W = 16;  // lane / pixel width
  localparam int SUM_W  = 18;  // three 16-bit terms cannot overflow 18 bits

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic signed [SUM_W-1:0] SAT_MAX = 18'sd32767;
  localparam logic signed [SUM_W-1:0] SAT_MIN = -18'sd32768;

  // Clamp an 18-bit signed sum into the signed 16-bit range.
  function automatic logic [DATA_W-1:0] sat16(input logic signed [SUM_W-1:0] s);
    logic [DATA_W-1:0] r;
    if (s > SAT_MAX) begin
      r = 16'h7fff;
    end else if (s < SAT_MIN) begin
      r = 16'h8000;
    end else begin
      r = s[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sa_output_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : sa_output_collector_if
// Purpose  : Bundles the SA-facing sample lanes and the downstream valid/ready
//            result stream of the output collector.
// Signals  : srt_sig, in1, in2, in3 - skewed SA samples (driven by master)
//            out_rdy                - downstream ready   (driven by master)
//            out, out_vld           - result pixel stream (driven by slave)
//            done, busy, err        - status             (driven by slave)
// Modports : master = stimulus/upstream side, slave = collector side
// Revision : 1.0 - initial release
// ============================================================================
interface sa_output_collector_if;
  import sa_output_collector_pkg::*;

  logic                     srt_sig;
  logic signed [DATA_W-1:0] in1;
  logic signed [DATA_W-1:0] in2;
  logic signed [DATA_W-1:0] in3;
  logic                     out_rdy;
  logic signed [DATA_W-1:0] out;
  logic                     out_vld;
  logic                     done;
  logic                     busy;
  logic                     err;

  modport master (
    output srt_sig, in1, in2, in3, out_rdy,
    input  out, out_vld, done, busy, err
  );

  modport slave (
    input  srt_sig, in1, in2, in3, out_rdy,
    output out, out_vld, done, busy, err
  );

endinterface
`default_nettype wire

// File: rtl/sa_deskew.sv
`default_nettype none
// ============================================================================
// Module   : sa_deskew
// Purpose  : Per-lane delay lines that undo the 0/1/2-cycle skew of the SA
//            rows. srt_sig follows lane 1 so avld_o marks aligned triples.
// Ports    : clk, rst            - clock, async active-high reset
//            srt_sig_i           - lane-1 sample strobe
//            in1_i, in2_i, in3_i - skewed lane partial sums
//            avld_o              - aligned-sample valid
//            a1_o, a2_o, a3_o    - aligned lane partial sums
// Revision : 1.0 - initial release
// ============================================================================
module sa_deskew
  import sa_output_collector_pkg::*;
#(
  parameter int IN1_DLY = 2,
  parameter int IN2_DLY = 1,
  parameter int IN3_DLY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     srt_sig_i,
  input  logic signed [DATA_W-1:0] in1_i,
  input  logic signed [DATA_W-1:0] in2_i,
  input  logic signed [DATA_W-1:0] in3_i,
  output logic                     avld_o,
  output logic signed [DATA_W-1:0] a1_o,
  output logic signed [DATA_W-1:0] a2_o,
  output logic signed [DATA_W-1:0] a3_o
);

  logic [2:0][DATA_W-1:0] lane_in;
  logic [2:0][DATA_W-1:0] lane_out;

  assign lane_in = {in3_i, in2_i, in1_i};

  generate
    for (genvar l = 0; l < 3; l++) begin : g_lane
      localparam int D = (l == 0) ? IN1_DLY : (l == 1) ? IN2_DLY : IN3_DLY;
      if (D == 0) begin : g_pass
        assign lane_out[l] = lane_in[l];
      end else begin : g_pipe
        logic [DATA_W-1:0] pipe_q [D];
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int i = 0; i < D; i++) pipe_q[i] <= '0;
          end else begin
            pipe_q[0] <= lane_in[l];
            for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
          end
        end
        assign lane_out[l] = pipe_q[D-1];
      end
    end

    // The strobe travels with lane 1, the lane it qualifies.
    if (IN1_DLY == 0) begin : g_srt_pass
      assign avld_o = srt_sig_i;
    end else begin : g_srt_pipe
      logic srt_q [IN1_DLY];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < IN1_DLY; i++) srt_q[i] <= 1'b0;
        end else begin
          srt_q[0] <= srt_sig_i;
          for (int i = 1; i < IN1_DLY; i++) srt_q[i] <= srt_q[i-1];
        end
      end
      assign avld_o = srt_q[IN1_DLY-1];
    end
  endgenerate

  assign a1_o = lane_out[0];
  assign a2_o = lane_out[1];
  assign a3_o = lane_out[2];

endmodule
`default_nettype wire

// File: rtl/sa_output_collector.sv
`default_nettype none
// ============================================================================
// Module   : sa_output_collector
// Purpose  : Deskews the three SA row lanes, sums and saturates them per
//            column, drops the leading edge columns, buffers one
//            OUT_ROWS x OUT_COLS map and streams it row-major via valid/ready.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - sa_output_collector_if.slave (lanes, stream, status)
// Revision : 1.0 - initial release
// ============================================================================
module sa_output_collector
  import sa_output_collector_pkg::*;
#(
  parameter int IN_COLS  = 7,
  parameter int DROP     = 2,
  parameter int OUT_ROWS = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  sa_output_collector_if.slave        bus
);

  localparam int OUT_COLS = IN_COLS - DROP;
  localparam int MAP_N    = OUT_ROWS * OUT_COLS;
  localparam int COL_W    = (IN_COLS  > 1) ? $clog2(IN_COLS)  : 1;
  localparam int ROW_W    = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam int PTR_W    = (MAP_N    > 1) ? $clog2(MAP_N)    : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_ROWS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAP_N - 1);

  // Aligned lanes
  logic                     avld;
  logic signed [DATA_W-1:0] a1;
  logic signed [DATA_W-1:0] a2;
  logic signed [DATA_W-1:0] a3;

  sa_deskew #(
    .IN1_DLY (2),
    .IN2_DLY (1),
    .IN3_DLY (0)
  ) u_deskew (
    .clk       (clk),
    .rst       (rst),
    .srt_sig_i (bus.srt_sig),
    .in1_i     (bus.in1),
    .in2_i     (bus.in2),
    .in3_i     (bus.in3),
    .avld_o    (avld),
    .a1_o      (a1),
    .a2_o      (a2),
    .a3_o      (a3)
  );

  // State and registered outputs
  state_t            state_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [DATA_W-1:0] out_q;
  logic              out_vld_q;
  logic              done_q;
  logic              busy_q;
  logic              err_q;
  logic [DATA_W-1:0] mem_q [MAP_N];

  // Datapath
  logic signed [SUM_W-1:0] sum;
  logic [DATA_W-1:0]       pix;
  logic                    accept;
  logic                    keep;
  logic                    last_sample;
  logic [PTR_W-1:0]        wr_idx;

  assign sum = {{(SUM_W-DATA_W){a1[DATA_W-1]}}, a1}
             + {{(SUM_W-DATA_W){a2[DATA_W-1]}}, a2}
             + {{(SUM_W-DATA_W){a3[DATA_W-1]}}, a3};
  assign pix = sat16(sum);

  // Samples are only taken while a map is being assembled; in DRAIN/DONE
  // they are discarded so the buffered map is never disturbed.
  assign accept      = avld && ((state_q == IDLE) || (state_q == COLLECT));
  assign keep        = (int'(col_q) >= DROP);
  assign last_sample = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign wr_idx      = PTR_W'(int'(row_q) * OUT_COLS + int'(col_q) - DROP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAP_N; i++) mem_q[i] <= '0;
    end else if (accept && keep) begin
      mem_q[wr_idx] <= pix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      rd_ptr_q  <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (avld && ((state_q == DRAIN) || (state_q == DONE))) begin
        err_q <= 1'b1;
      end

      // Column/row counters advance only on accepted samples, so srt_sig
      // gaps simply stall them.
      if (accept) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end

      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= last_sample ? DRAIN : COLLECT;
            busy_q  <= 1'b1;
          end
        end
        COLLECT: begin
          if (accept && last_sample) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // First DRAIN cycle preloads pixel 0; after that each handshake
          // advances to the next pixel without a bubble.
          if (!out_vld_q) begin
            out_vld_q <= 1'b1;
            out_q     <= mem_q[rd_ptr_q];
          end else if (bus.out_rdy) begin
            if (rd_ptr_q == PTR_LAST) begin
              state_q   <= DONE;
              out_vld_q <= 1'b0;
              out_q     <= '0;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              rd_ptr_q <= rd_ptr_q + PTR_W'(1);
              out_q    <= mem_q[rd_ptr_q + PTR_W'(1)];
            end
          end
        end
        DONE: begin
          state_q  <= IDLE;
          col_q    <= '0;
          row_q    <= '0;
          rd_ptr_q <= '0;
        end
      endcase
    end
  end

  assign bus.out     = out_q;
  assign bus.out_vld = out_vld_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sa_output_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_output_collector
// Purpose  : Directed self-checking bench for sa_output_collector. Drives
//            skewed SA lanes, keeps a queue of expected pixels and compares
//            them against the drained stream.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa_output_collector;

  localparam int IN_COLS  = 7;
  localparam int DROP     = 2;
  localparam int OUT_ROWS = 5;
  localparam int MAP_N    = OUT_ROWS * (IN_COLS - DROP);

  logic clk;
  logic rst;

  sa_output_collector_if bus ();

  sa_output_collector #(
    .IN_COLS  (IN_COLS),
    .DROP     (DROP),
    .OUT_ROWS (OUT_ROWS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int sb[$];
  int pix_cnt  = 0;
  int done_cnt = 0;
  logic exp_err = 1'b0;

  // Lane partners still to be driven on in2 (1 cycle late) and in3 (2 late)
  int b_m1 = 0;
  int c_m1 = 0;
  int c_m2 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // One clock of upstream stimulus with the SA lane skew applied.
  task automatic drive_cycle(input bit v, input int a, input int b, input int c);
    @(posedge clk); #1;
    bus.srt_sig = v;
    bus.in1     = v ? 16'(a) : 16'sd0;
    bus.in2     = 16'(b_m1);
    bus.in3     = 16'(c_m2);
    c_m2 = c_m1;
    c_m1 = v ? c : 0;
    b_m1 = v ? b : 0;
  endtask

  task automatic send_map(input int mode, input bit gaps);
    int a, b, c;
    pix_cnt  = 0;
    done_cnt = 0;
    for (int r = 0; r < OUT_ROWS; r++) begin
      for (int col = 0; col < IN_COLS; col++) begin
        if (gaps && r == 2 && col == 3) begin
          repeat (3) drive_cycle(1'b0, 0, 0, 0);
        end
        case (mode)
          1:       begin a = 30000;      b = 30000;    c = 30000;  end
          2:       begin a = -30000;     b = -30000;   c = -30000; end
          3:       begin a = -1000 * r;  b = 37 * col; c = -5;     end
          default: begin a = r;          b = col;      c = 1;      end
        endcase
        drive_cycle(1'b1, a, b, c);
        if (col >= DROP) sb.push_back(sat(a + b + c));
      end
    end
    drive_cycle(1'b0, 0, 0, 0);
    drive_cycle(1'b0, 0, 0, 0);
  endtask

  task automatic wait_done(input bit bp);
    bit seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(posedge clk); #1;
      bus.out_rdy = bp ? (k % 3 == 0) : 1'b1;
      @(negedge clk); #1;
      if (done_cnt > 0) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    bus.out_rdy = 1'b1;
    @(negedge clk); #1;
    chk("done_width",   32'(bus.done),    32'd0);
    chk("vld_after",    32'(bus.out_vld), 32'd0);
    chk("busy_after",   32'(bus.busy),    32'd0);
    chk("done_count",   32'(done_cnt),    32'd1);
    chk("pixel_count",  32'(pix_cnt),     32'(MAP_N));
    chk("queue_empty",  32'(sb.size()),   32'd0);
    chk("err_state",    32'(bus.err),     32'(exp_err));
  endtask

  // Output monitor: scoreboard pops, hold-under-backpressure and done timing.
  logic              prev_vld = 1'b0;
  logic              prev_rdy = 1'b0;
  logic signed [15:0] prev_out = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_vld && !prev_rdy) begin
        chk("hold_vld", 32'(bus.out_vld), 32'd1);
        chk("hold_out", 32'(bus.out), 32'(prev_out));
      end
      if (bus.out_vld && bus.out_rdy) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) chk("pixel", 32'(bus.out), 32'(sb.pop_front()));
        pix_cnt++;
      end
      if (bus.done) begin
        chk("done_after_last", 32'(pix_cnt), 32'(MAP_N));
        chk("done_vld_low",    32'(bus.out_vld), 32'd0);
        done_cnt++;
      end
      prev_vld = bus.out_vld;
      prev_rdy = bus.out_rdy;
      prev_out = bus.out;
    end else begin
      prev_vld = 1'b0;
      prev_rdy = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    bus.srt_sig = 1'b0;
    bus.in1     = '0;
    bus.in2     = '0;
    bus.in3     = '0;
    bus.out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset then idle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", {11'd0, bus.out, bus.out_vld, bus.done, bus.busy, bus.err}, 32'd0);
    end

    // 2: full map, plus first-valid latency
    send_map(0, 1'b0);
    @(negedge clk);
    chk("lat_before_write", 32'(bus.out_vld), 32'd0);
    @(negedge clk);
    chk("lat_write_vld", 32'(bus.out_vld), 32'd0);
    chk("lat_write_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("lat_first_vld", 32'(bus.out_vld), 32'd1);
    wait_done(1'b0);

    // 3: saturation both ways
    send_map(1, 1'b0);
    wait_done(1'b0);
    send_map(2, 1'b0);
    wait_done(1'b0);

    // 4: backpressure 1,0,0,1,...
    send_map(0, 1'b0);
    wait_done(1'b1);

    // 5: srt_sig gap mid-row
    send_map(0, 1'b0 | 1'b1);
    wait_done(1'b0);

    // 6a: sample during DRAIN sets err, map unchanged
    bus.out_rdy = 1'b0;
    send_map(0, 1'b0);
    repeat (4) @(negedge clk);
    chk("drain_hold_vld", 32'(bus.out_vld), 32'd1);
    drive_cycle(1'b1, 999, 999, 999);
    drive_cycle(1'b0, 0, 0, 0);
    drive_cycle(1'b0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("err_set", 32'(bus.err), 32'd1);
    exp_err = 1'b1;
    wait_done(1'b0);

    // 6b: reset at pixel 10, then a fresh map
    send_map(0, 1'b0);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #3;
      if (pix_cnt >= 10) break;
    end
    chk("abort_at_pixel", 32'(pix_cnt), 32'd10);
    rst = 1'b1;
    #1;
    chk("rst_out",  32'(bus.out),     32'd0);
    chk("rst_vld",  32'(bus.out_vld), 32'd0);
    chk("rst_busy", 32'(bus.busy),    32'd0);
    chk("rst_err",  32'(bus.err),     32'd0);
    chk("rst_done", 32'(bus.done),    32'd0);
    sb.delete();
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send_map(3, 1'b0);
    wait_done(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
